ledmatrix_spi_tx: RTL and testbench

//  Serial transmitter for a chain of four cascaded MAX7219 8x8 LED drivers.

---
 rtl/ledmatrix_spi_tx_if.sv | 12 +
 rtl/ledmatrix_spi_tx.sv | 183 ++++++++++++++++++
 tb/tb_ledmatrix_spi_tx.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ledmatrix_spi_tx_if.sv
// Frame handshake between the frame generator (master) and the MAX7219 serial transmitter (slave).
interface ledmatrix_spi_tx_if #(
  parameter int WORD_W = 64
);
  logic [WORD_W-1:0] data;
  logic              start;
  logic              ready;
  logic              done;

  modport master (output data, output start, input ready, input done);
  modport slave  (input data, input start, output ready, output done);
endinterface

// File: rtl/ledmatrix_spi_tx.sv
// Serial transmitter for a four-device MAX7219 chain: one WORD_W-bit frame per CS low window.
// Optional LEDMATRIX_SPI_CHANGE_DET_EN: idle transmitter also starts when data differs from the last frame sent.
module ledmatrix_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8,
  parameter int WORD_W  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  ledmatrix_spi_tx_if.slave   host,
  output logic                max_din,
  output logic                max_sclk,
  output logic                max_cs
);

  localparam int MAX_HALF = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
  localparam int BIT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    GAP      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  // Bits still to be presented after the one currently on DIN, MSB next.
  logic [WORD_W-2:0] rest_q, rest_d;
  logic              din_q, din_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              trig;
  logic              cnt_zero;

`ifdef LEDMATRIX_SPI_CHANGE_DET_EN
  logic [WORD_W-1:0] last_q, last_d;

  assign trig = host.start | (host.data != last_q);
`else
  assign trig = host.start;
`endif

  assign cnt_zero   = (cnt_q == {CNT_W{1'b0}});
  assign max_din    = din_q;
  assign max_sclk   = sclk_q;
  assign max_cs     = cs_q;
  assign host.ready = ready_q;
  assign host.done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    rest_d  = rest_q;
    din_d   = din_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    ready_d = ready_q;
    done_d  = 1'b0;
`ifdef LEDMATRIX_SPI_CHANGE_DET_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (trig && ready_q) begin
          rest_d  = host.data[WORD_W-2:0];
          din_d   = host.data[WORD_W-1];
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          bit_d   = BIT_LOAD;
          cnt_d   = DIV_LOAD;
          state_d = SETUP;
`ifdef LEDMATRIX_SPI_CHANGE_DET_EN
          last_d  = host.data;
`endif
        end else begin
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      SETUP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sclk_d  = 1'b1;
          cnt_d   = DIV_LOAD;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sclk_d  = 1'b0;
          cnt_d   = DIV_LOAD;
          state_d = SHIFT_LO;
          // DIN moves with the falling edge so it is stable for the whole next high phase.
          if (bit_q != {BIT_W{1'b0}}) begin
            din_d  = rest_q[WORD_W-2];
            rest_d = {rest_q[WORD_W-3:0], 1'b0};
          end else begin
            din_d  = din_q;
          end
        end
      end
      SHIFT_LO: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bit_q != {BIT_W{1'b0}}) begin
          bit_d   = bit_q - BIT_W'(1);
          sclk_d  = 1'b1;
          cnt_d   = DIV_LOAD;
          state_d = SHIFT_HI;
        end else begin
          cs_d    = 1'b1;
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ready_d = 1'b1;
          done_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      rest_q  <= {(WORD_W-1){1'b0}};
      din_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rest_q  <= rest_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef LEDMATRIX_SPI_CHANGE_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= {WORD_W{1'b0}};
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_ledmatrix_spi_tx.sv
// Randomised bench for ledmatrix_spi_tx: a cycle-indexed reference model of the pin waveforms
// plus a SPI capture monitor; directed checks pin latency, back-to-back spacing and reset abort.
module tb_ledmatrix_spi_tx;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;
  localparam int W       = 64;
  localparam int SH_END  = CLK_DIV * (1 + 2 * W);
  localparam int LAT     = SH_END + CS_GAP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic max_din, max_sclk, max_cs;

  always #5 clk = ~clk;

  ledmatrix_spi_tx_if #(.WORD_W(W)) bus ();

  ledmatrix_spi_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .WORD_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (bus),
    .max_din  (max_din),
    .max_sclk (max_sclk),
    .max_cs   (max_cs)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  // Expected {cs, sclk, din} k cycles after the accepting edge, from the frame timing rules.
  function automatic logic [2:0] exp_pins(input int k, input logic [63:0] f);
    int j, i, nb;
    bit hi;
    if (k < CLK_DIV) return {1'b0, 1'b0, f[W-1]};
    if (k >= SH_END) return {1'b1, 1'b0, f[0]};
    j  = k - CLK_DIV;
    i  = j / (2 * CLK_DIV);
    hi = (j % (2 * CLK_DIV)) < CLK_DIV;
    nb = hi ? i : ((i < W - 1) ? i + 1 : W - 1);
    return {1'b0, hi, f[W-1-nb]};
  endfunction

  // Reference model: idle/busy, cycle index into the current frame, and the queue of frames owed.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_k = 0;
  logic [63:0] m_frame = '0;
  logic [63:0] m_last = '0;
  logic [63:0] exp_q[$];
  bit          chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_busy && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      m_busy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
      m_last = '0;
    end else begin
`ifdef LEDMATRIX_SPI_CHANGE_DET_EN
      chg = (bus.data !== m_last);
`else
      chg = 1'b0;
`endif
      m_done = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == LAT) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.start || chg) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_frame = bus.data;
        m_last  = bus.data;
        exp_q.push_back(bus.data);
      end
    end
  end

  // Per-cycle compare plus CS-high gap and done counting, all on the falling edge.
  int   dones = 0;
  int   ncyc = 0;
  int   rise_cyc = 0;
  int   last_gap = 0;
  logic cs_prev = 1'b1;
  logic [2:0] ep;

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      check("reset_pins", {bus.ready, bus.done, max_cs, max_sclk, max_din}, {59'd0, 5'b10100});
    end else if (m_busy) begin
      ep = exp_pins(m_k, m_frame);
      check("busy_pins", {bus.ready, bus.done, max_cs, max_sclk, max_din}, {59'd0, 2'b00, ep});
    end else begin
      check("idle_pins", {bus.ready, bus.done, max_cs, max_sclk}, {60'd0, 1'b1, m_done, 2'b10});
    end
    if (bus.done === 1'b1) dones++;
    if (max_cs && !cs_prev) rise_cyc = ncyc;
    if (!max_cs && cs_prev) last_gap = ncyc - rise_cyc;
    cs_prev = max_cs;
  end

  // SPI slave model: shift DIN on SCLK rise, close the frame on CS rise.
  logic [63:0] cap = '0;
  logic [63:0] last_cap = '0;
  int          cap_n = 0;
  int          frames = 0;

  always @(posedge max_sclk) begin
    check("cs_low_at_sclk", {63'd0, max_cs}, 64'd0);
    cap = {cap[62:0], max_din};
    cap_n++;
  end

  always @(negedge max_cs) cap_n = 0;

  always @(posedge max_cs) begin
    if (rst_n === 1'b1) begin
      check("bit_count", cap_n, 64'd64);
      if (exp_q.size() == 0) begin
        timeout("frame_unexpected");
      end else begin
        check("frame_bits", cap, exp_q.pop_front());
      end
      frames++;
      last_cap = cap;
    end
    cap_n = 0;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input logic val, input int budget, input string name);
    int n = 0;
    while (bus.ready !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== val) timeout(name);
  endtask

  task automatic wait_done(input int budget, input string name, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) timeout(name);
  endtask

  task automatic send(input logic [63:0] d);
    @(negedge clk);
    bus.data  = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [63:0] fa, fb;
  int f0, d0, n;

  initial begin
    bus.data  = '0;
    bus.start = 1'b0;

    // Reset values
    idle(3);
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_cs", {63'd0, max_cs}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // Single frame latency and content
    f0 = frames;
    send(64'h0C010C010C010C01);
    wait_done(LAT + 50, "done_wait", n);
    check("latency", n, 64'd262);
    check("frame_literal", last_cap, 64'h0C010C010C010C01);
    check("one_frame", frames - f0, 64'd1);

    // Start during a frame is ignored
    idle(3);
    f0 = frames;
    d0 = dones;
    send({$urandom, $urandom});
    idle(48);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    idle(LAT + 20);
    check("ignored_frames", frames - f0, 64'd1);
    check("ignored_dones", dones - d0, 64'd1);

    // Start held high across two frames
    f0 = frames;
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    @(negedge clk);
    bus.data  = fa;
    bus.start = 1'b1;
    wait_ready(1'b0, 5, "accept_a");
    bus.data = fb;
    wait_done(LAT + 10, "done_a", n);
    @(negedge clk);
    check("b2b_accept", {63'd0, bus.ready}, 64'd0);
    bus.start = 1'b0;
    idle(CLK_DIV * 3);
    check("cs_gap", last_gap, 64'd5);
    wait_done(LAT + 10, "done_b", n);
    idle(2);
    check("b2b_frames", frames - f0, 64'd2);
    check("b2b_last", last_cap, fb);

    // Random frames with spurious mid-frame starts
    for (int r = 0; r < 6; r++) begin
      wait_ready(1'b1, LAT + 10, "rand_ready");
      idle($urandom_range(0, 5));
      send({$urandom, $urandom});
      idle($urandom_range(1, LAT - 10));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_ready(1'b1, LAT + 10, "rand_end");
    idle(3);

    // Reset in the middle of the shift
    f0 = frames;
    d0 = dones;
    send({$urandom, $urandom});
    n = 0;
    while (cap_n < 30 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    if (cap_n < 30) timeout("reach_bit30");
    #1 rst_n = 1'b0;
    bus.data = '0;
    #1;
    check("abort_cs", {63'd0, max_cs}, 64'd1);
    check("abort_sclk", {63'd0, max_sclk}, 64'd0);
    idle(4);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(LAT + 10);
    check("abort_no_frame", frames - f0, 64'd0);
    check("abort_no_done", dones - d0, 64'd0);
    fa = {$urandom, $urandom};
    send(fa);
    wait_done(LAT + 10, "after_abort", n);
    check("after_abort_frame", last_cap, fa);
    check("after_abort_count", frames - f0, 64'd1);

    // Unstrobed data change
    @(negedge clk);
    rst_n = 1'b0;
    bus.data  = '0;
    bus.start = 1'b0;
    idle(3);
    @(negedge clk);
    #2 rst_n = 1'b1;
    f0 = frames;
    idle(20);
    check("chg_zero_none", frames - f0, 64'd0);
    @(negedge clk);
    bus.data = 64'h0F000F000F000F00;
    idle(LAT + 20);
`ifdef LEDMATRIX_SPI_CHANGE_DET_EN
    check("chg_one", frames - f0, 64'd1);
    check("chg_frame", last_cap, 64'h0F000F000F000F00);
    idle(LAT);
    check("chg_hold", frames - f0, 64'd1);
`else
    check("chg_none", frames - f0, 64'd0);
    idle(LAT);
    check("chg_hold", frames - f0, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
